// File: rtl/serial_twos_comp.sv
// Bit-serial two's-complement negate / absolute-value unit.
// Processes one bit per cycle, LSB first: copy up to the first 1, invert the rest.
module serial_twos_comp #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             mode,
  input  logic [WIDTH-1:0] I,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] O,
  output logic             ovf
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] sr_q, sr_d;
  logic [WIDTH-1:0] r_q, r_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             inv_q, inv_d;
  logic             msb_q, msb_d;
  logic             seen_q, seen_d;
  logic             lowz_q, lowz_d;
  logic [WIDTH-1:0] o_q, o_d;
  logic             ovf_q, ovf_d;
  logic             done_q, done_d;
  logic             r_bit;
  logic             load;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      sr_q    <= '0;
      r_q     <= '0;
      cnt_q   <= '0;
      inv_q   <= 1'b0;
      msb_q   <= 1'b0;
      seen_q  <= 1'b0;
      lowz_q  <= 1'b1;
      o_q     <= '0;
      ovf_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      sr_q    <= sr_d;
      r_q     <= r_d;
      cnt_q   <= cnt_d;
      inv_q   <= inv_d;
      msb_q   <= msb_d;
      seen_q  <= seen_d;
      lowz_q  <= lowz_d;
      o_q     <= o_d;
      ovf_q   <= ovf_d;
      done_q  <= done_d;
    end
  end

  // DONE accepts a new request as IDLE does, giving back-to-back throughput.
  assign load = start && ((state_q == IDLE) || (state_q == DONE));

  always_comb begin
    state_d = state_q;
    sr_d    = sr_q;
    r_d     = r_q;
    cnt_d   = cnt_q;
    inv_d   = inv_q;
    msb_d   = msb_q;
    seen_d  = seen_q;
    lowz_d  = lowz_q;
    o_d     = o_q;
    ovf_d   = ovf_q;
    done_d  = 1'b0;
    r_bit   = 1'b0;

    case (state_q)
      IDLE: ;
      SHIFT: begin
        r_bit  = (inv_q & seen_q) ? ~sr_q[0] : sr_q[0];
        seen_d = seen_q | sr_q[0];
        r_d    = {r_bit, r_q[WIDTH-1:1]};
        sr_d   = sr_q >> 1;
        if (cnt_q != LAST) begin
          // lowz covers only the bits below the MSB; it flags 100..0.
          lowz_d = lowz_q & ~sr_q[0];
          cnt_d  = cnt_q + 1'b1;
        end else begin
          state_d = DONE;
        end
      end
      DONE: begin
        o_d     = r_q;
        ovf_d   = inv_q & msb_q & lowz_q;
        done_d  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    if (load) begin
      sr_d    = I;
      inv_d   = ~mode | I[WIDTH-1];
      msb_d   = I[WIDTH-1];
      seen_d  = 1'b0;
      lowz_d  = 1'b1;
      cnt_d   = '0;
      state_d = SHIFT;
    end
  end

  assign busy = (state_q == SHIFT);
  assign done = done_q;
  assign O    = o_q;
  assign ovf  = ovf_q;

endmodule

// File: tb/tb_serial_twos_comp.sv
// Directed bench for serial_twos_comp (WIDTH=4 and WIDTH=8) with a result scoreboard.
module tb_serial_twos_comp;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic       start_4, mode_4, busy_4, done_4, ovf_4;
  logic [3:0] i_4, o_4;
  logic       start_8, mode_8, busy_8, done_8, ovf_8;
  logic [7:0] i_8, o_8;

  serial_twos_comp #(.WIDTH(4)) dut4 (
    .clk(clk), .rst(rst), .start(start_4), .mode(mode_4), .I(i_4),
    .busy(busy_4), .done(done_4), .O(o_4), .ovf(ovf_4)
  );

  serial_twos_comp #(.WIDTH(8)) dut8 (
    .clk(clk), .rst(rst), .start(start_8), .mode(mode_8), .I(i_8),
    .busy(busy_8), .done(done_8), .O(o_8), .ovf(ovf_8)
  );

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic [7:0] o;
    logic       ovf;
  } exp_t;

  exp_t q4[$];
  exp_t q8[$];
  exp_t e4, e8;

  function automatic exp_t model(input int w, input logic m, input logic [7:0] a);
    exp_t e;
    int   ai   = int'(a);
    int   mask = (1 << w) - 1;
    bit   neg  = (m == 1'b0) || (a[w-1] == 1'b1);
    e.o   = neg ? 8'((0 - ai) & mask) : a;
    e.ovf = neg && (ai == (1 << (w - 1)));
    return e;
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  // Result monitors: every done pulse must match the oldest pending expectation.
  always begin
    @(posedge clk); #1;
    if (done_4 === 1'b1) begin
      checks++;
      assert (q4.size() != 0) else begin
        errors++;
        $error("FAIL dut4_spurious_done: done=%0b with %0d pending", done_4, q4.size());
      end
      if (q4.size() != 0) begin
        e4 = q4.pop_front();
        chk("dut4_O", 32'(o_4), 32'(e4.o[3:0]));
        chk("dut4_ovf", 32'(ovf_4), 32'(e4.ovf));
        $display("dut4 result O=%b ovf=%b (expected %b/%b)", o_4, ovf_4, e4.o[3:0], e4.ovf);
      end
    end
  end

  always begin
    @(posedge clk); #1;
    if (done_8 === 1'b1) begin
      checks++;
      assert (q8.size() != 0) else begin
        errors++;
        $error("FAIL dut8_spurious_done: done=%0b with %0d pending", done_8, q8.size());
      end
      if (q8.size() != 0) begin
        e8 = q8.pop_front();
        chk("dut8_O", 32'(o_8), 32'(e8.o));
        chk("dut8_ovf", 32'(ovf_8), 32'(e8.ovf));
        $display("dut8 result O=%h ovf=%b (expected %h/%b)", o_8, ovf_8, e8.o, e8.ovf);
      end
    end
  end

  // Drive a request for one cycle; returns #1 after the accepting edge.
  task automatic go4(input logic m, input logic [3:0] a, input bit push);
    mode_4 = m; i_4 = a; start_4 = 1'b1;
    if (push) q4.push_back(model(4, m, {4'b0, a}));
    @(posedge clk); #1;
    start_4 = 1'b0;
  endtask

  task automatic go8(input logic m, input logic [7:0] a);
    mode_8 = m; i_8 = a; start_8 = 1'b1;
    q8.push_back(model(8, m, a));
    @(posedge clk); #1;
    start_8 = 1'b0;
  endtask

  task automatic wait4(input string tag, input int c0, input int lat);
    int c = c0;
    bit seen = 1'b0;
    while (!seen && c < 40) begin
      @(posedge clk); #1;
      c++;
      if (done_4 === 1'b1) seen = 1'b1;
    end
    checks++;
    assert (seen && c == lat) else begin
      errors++;
      $error("FAIL %s_latency: observed %0d cycles (seen=%0b) expected %0d", tag, c, seen, lat);
    end
  endtask

  task automatic wait8(input string tag, input int lat);
    int c = 0;
    bit seen = 1'b0;
    while (!seen && c < 40) begin
      @(posedge clk); #1;
      c++;
      if (done_8 === 1'b1) seen = 1'b1;
    end
    checks++;
    assert (seen && c == lat) else begin
      errors++;
      $error("FAIL %s_latency: observed %0d cycles (seen=%0b) expected %0d", tag, c, seen, lat);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    start_4 = 1'b0; mode_4 = 1'b0; i_4 = '0;
    start_8 = 1'b0; mode_8 = 1'b0; i_8 = '0;

    // T1 reset
    repeat (2) begin @(posedge clk); #1; end
    chk("reset_O", 32'(o_4), 32'h0);
    chk("reset_ovf", 32'(ovf_4), 32'h0);
    chk("reset_busy", 32'(busy_4), 32'h0);
    chk("reset_done", 32'(done_4), 32'h0);
    chk("reset_O8", 32'(o_8), 32'h0);
    rst = 1'b0;
    @(posedge clk); #1;

    // T2 negate sweep
    for (int a = 0; a < 16; a++) begin
      go4(1'b0, 4'(a), 1'b1);
      chk("busy_in_shift", 32'(busy_4), 32'h1);
      wait4("neg", 0, 5);
    end

    // T3 absolute value with literal expectations
    q4.push_back(exp_t'{o: 8'h05, ovf: 1'b0}); go4(1'b1, 4'b1011, 1'b0); wait4("abs", 0, 5);
    q4.push_back(exp_t'{o: 8'h01, ovf: 1'b0}); go4(1'b1, 4'b1111, 1'b0); wait4("abs", 0, 5);
    q4.push_back(exp_t'{o: 8'h03, ovf: 1'b0}); go4(1'b1, 4'b0011, 1'b0); wait4("abs", 0, 5);
    q4.push_back(exp_t'{o: 8'h08, ovf: 1'b1}); go4(1'b1, 4'b1000, 1'b0); wait4("abs", 0, 5);

    // T4 start ignored during SHIFT, then held through DONE
    q4.push_back(exp_t'{o: 8'h0D, ovf: 1'b0}); go4(1'b0, 4'b0011, 1'b0);
    @(posedge clk); #1;
    start_4 = 1'b1; i_4 = 4'b0101;
    @(posedge clk); #1;
    start_4 = 1'b0;
    chk("busy_after_ignored_start", 32'(busy_4), 32'h1);
    start_4 = 1'b1; i_4 = 4'b0010; mode_4 = 1'b0;
    q4.push_back(exp_t'{o: 8'h0E, ovf: 1'b0});
    wait4("ignored_start", 2, 5);
    start_4 = 1'b0;
    wait4("back_to_back", 0, 5);

    // T5 reset mid-operation
    go4(1'b0, 4'b0110, 1'b0);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("midreset_busy", 32'(busy_4), 32'h0);
    chk("midreset_done", 32'(done_4), 32'h0);
    chk("midreset_O", 32'(o_4), 32'h0);
    chk("midreset_ovf", 32'(ovf_4), 32'h0);
    repeat (6) begin @(posedge clk); #1; end
    go4(1'b0, 4'b0001, 1'b1);
    wait4("after_reset", 0, 5);

    // T6 WIDTH=8
    go8(1'b0, 8'h01); wait8("w8_neg01", 9);
    go8(1'b0, 8'h7F); wait8("w8_neg7f", 9);
    go8(1'b0, 8'h80); wait8("w8_neg80", 9);
    go8(1'b1, 8'hC0); wait8("w8_absc0", 9);
    go8(1'b1, 8'h35); wait8("w8_abs35", 9);

    repeat (3) begin @(posedge clk); #1; end
    chk("q4_drained", 32'(q4.size()), 32'h0);
    chk("q8_drained", 32'(q8.size()), 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
